// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing and one-hot receiver/transmitter state encodings.
package uart_pkg;

  // 25.2 MHz pixel clock / 115200 baud
  localparam int CLK_CYCLES_PER_BIT_DEFAULT = 219;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_START = 5'b00010,
    ST_DATA  = 5'b00100,
    ST_STOP  = 5'b01000,
    ST_DONE  = 5'b10000
  } uart_state_t;

  // Cycles from a detected start edge to the middle of the start bit.
  function automatic int half_bit_count(input int cycles_per_bit);
    return (cycles_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; each bit resets to its PRESET value.
module sync_2ff #(
  parameter int               WIDTH  = 1,
  parameter logic [WIDTH-1:0] PRESET = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg <= PRESET[gi];
          sync_reg <= PRESET[gi];
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, framing check, one-cycle result pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_CYCLES_PER_BIT = CLK_CYCLES_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic       rx_active,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error
);

  localparam int CNT_W = $clog2(CLK_CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_bit_count(CLK_CYCLES_PER_BIT));
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLK_CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  uart_state_t      state_reg, state_next;
  logic             rx_s;
  logic             rx_prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       data_reg;
  logic             data_valid_reg;
  logic             frame_error_reg;
  logic             rx_active_reg;

  sync_2ff #(
    .WIDTH (1),
    .PRESET(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx_serial),
    .q    (rx_s)
  );

  // Only a 1->0 transition starts a frame, so a line stuck low never re-triggers.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (rx_prev_reg && !rx_s) state_next = ST_START;
      ST_START: if (cnt_reg == HALF_CNT) state_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (cnt_reg == FULL_CNT && bit_idx_reg == 3'd7) state_next = ST_STOP;
      ST_STOP:  if (cnt_reg == FULL_CNT) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      rx_prev_reg     <= 1'b1;
      cnt_reg         <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      data_reg        <= '0;
      data_valid_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      rx_active_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rx_prev_reg     <= rx_s;
      data_valid_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          cnt_reg     <= '0;
          bit_idx_reg <= '0;
        end
        ST_START: begin
          if (cnt_reg == HALF_CNT) begin
            cnt_reg       <= '0;
            rx_active_reg <= !rx_s;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_reg == FULL_CNT) begin
            cnt_reg                <= '0;
            shift_reg[bit_idx_reg] <= rx_s;
            bit_idx_reg            <= bit_idx_reg + 3'd1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_reg == FULL_CNT) begin
            cnt_reg       <= '0;
            rx_active_reg <= 1'b0;
            // A low stop bit discards the byte; data keeps the last good frame.
            if (rx_s) begin
              data_reg       <= shift_reg;
              data_valid_reg <= 1'b1;
            end else begin
              frame_error_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: begin
          cnt_reg <= '0;
        end
      endcase
    end
  end

  assign rx_active   = rx_active_reg;
  assign data        = data_reg;
  assign data_valid  = data_valid_reg;
  assign frame_error = frame_error_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed 8N1 frames against an event-queue model of the receiver.
module tb_uart_rx;

  localparam int N   = 219;
  localparam int H   = (N - 1) / 2;
  localparam int LAT = 9 * N + H + 5;

  typedef struct {
    logic       is_ferr;
    logic [7:0] data;
    int         due;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       rx_serial;
  logic       rx_active;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;

  int         cyc;
  int         checks;
  int         errors;
  ev_t        exp_q[$];
  logic [7:0] model_data;
  logic       act_valid;
  int         act_fall;
  int         last_fall;
  int         dv_count;
  int         fe_count;
  int         last_dv_cyc;
  int         prev_dv_cyc;

  uart_rx #(.CLK_CYCLES_PER_BIT(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_serial  (rx_serial),
    .rx_active  (rx_active),
    .data       (data),
    .data_valid (data_valid),
    .frame_error(frame_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: outputs sampled 1 time unit after each rising edge.
  always begin
    ev_t ev;
    @(posedge clk);
    cyc++;
    #1;
    if (reset) begin
      check("reset_data", data, 0);
      check("reset_data_valid", data_valid, 0);
      check("reset_frame_error", frame_error, 0);
      check("reset_rx_active", rx_active, 0);
    end else begin
      check("dv_fe_exclusive", data_valid & frame_error, 0);
      if (data_valid || frame_error) begin
        check("pulse_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          check("pulse_kind_ferr", frame_error, ev.is_ferr);
          check("pulse_time_window", int'(cyc >= ev.due - 2 && cyc <= ev.due + 2), 1);
          if (!ev.is_ferr) model_data = ev.data;
        end
        if (data_valid) begin
          dv_count++;
          prev_dv_cyc = last_dv_cyc;
          last_dv_cyc = cyc;
          $display("cycle %0d: data_valid data=%02h", cyc, data);
        end else begin
          fe_count++;
          $display("cycle %0d: frame_error data=%02h", cyc, data);
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due + 2) begin
        check("pulse_missing", int'(data_valid | frame_error), 1);
        void'(exp_q.pop_front());
      end
      check("data_hold", data, model_data);
      if (act_valid && cyc >= act_fall + H + 6 && cyc <= act_fall + 9 * N + H + 1)
        check("rx_active_in_frame", rx_active, 1);
      else if (!act_valid || cyc < act_fall + H + 2 || cyc > act_fall + 9 * N + H + 6)
        check("rx_active_idle", rx_active, 0);
    end
  end

  // Called on a falling clock edge; returns on a falling edge, so frames can abut.
  task automatic send_frame(input logic [7:0] b, input int rate, input logic stop_bit,
                            input int abort_bit);
    ev_t ev;
    rx_serial = 1'b0;
    last_fall = cyc;
    act_fall  = cyc;
    act_valid = 1'b1;
    if (abort_bit > 7) begin
      ev.is_ferr = !stop_bit;
      ev.data    = b;
      ev.due     = cyc + LAT;
      exp_q.push_back(ev);
    end
    repeat (rate) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      if (i == abort_bit) begin
        repeat (rate / 2) @(negedge clk);
        reset      = 1'b1;
        act_valid  = 1'b0;
        model_data = 8'h00;
        @(negedge clk);
        reset     = 1'b0;
        rx_serial = 1'b1;
        return;
      end
      repeat (rate) @(negedge clk);
    end
    rx_serial = stop_bit;
    repeat (rate) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int dv0;
    int fe0;
    int fall_a5;
    cyc = 0; checks = 0; errors = 0;
    model_data = 8'h00; act_valid = 1'b0; act_fall = 0; last_fall = 0;
    dv_count = 0; fe_count = 0; last_dv_cyc = 0; prev_dv_cyc = 0;
    reset = 1'b1;
    rx_serial = 1'b1;
    idle(5);
    reset = 1'b0;
    idle(20);

    // Single byte 0xA5
    send_frame(8'hA5, N, 1'b1, 8);
    fall_a5 = last_fall;
    idle(100);
    check("a5_dv_count", dv_count, 1);
    check("a5_fe_count", fe_count, 0);
    check("a5_data", data, 8'hA5);
    check("a5_latency_2083_2087",
          int'(last_dv_cyc - fall_a5 >= 2083 && last_dv_cyc - fall_a5 <= 2087), 1);

    // Back-to-back 0x00, 0xFF with no idle between frames
    dv0 = dv_count;
    send_frame(8'h00, N, 1'b1, 8);
    send_frame(8'hFF, N, 1'b1, 8);
    idle(100);
    check("b2b_dv_count", dv_count - dv0, 2);
    check("b2b_spacing_2188_2192",
          int'(last_dv_cyc - prev_dv_cyc >= 2188 && last_dv_cyc - prev_dv_cyc <= 2192), 1);
    check("b2b_data", data, 8'hFF);

    // 60-cycle glitch, then 0x3C
    dv0 = dv_count; fe0 = fe_count;
    rx_serial = 1'b0;
    idle(60);
    rx_serial = 1'b1;
    idle(400);
    check("glitch_no_dv", dv_count, dv0);
    check("glitch_no_fe", fe_count, fe0);
    send_frame(8'h3C, N, 1'b1, 8);
    idle(100);
    check("after_glitch_data", data, 8'h3C);

    // 0x81 with a low stop bit, line then held low
    dv0 = dv_count; fe0 = fe_count;
    send_frame(8'h81, N, 1'b0, 8);
    idle(5000);
    rx_serial = 1'b1;
    idle(300);
    check("ferr_count", fe_count - fe0, 1);
    check("ferr_no_dv", dv_count, dv0);
    check("ferr_data_unchanged", data, 8'h3C);

    // Reset during bit 4 of 0x5A, then 0xC3
    dv0 = dv_count; fe0 = fe_count;
    send_frame(8'h5A, N, 1'b1, 4);
    idle(500);
    check("abort_no_dv", dv_count, dv0);
    check("abort_no_fe", fe_count, fe0);
    check("abort_data_cleared", data, 8'h00);
    send_frame(8'hC3, N, 1'b1, 8);
    idle(100);
    check("after_abort_data", data, 8'hC3);

    // 0x96 at sender rate offsets of about +-2.3%
    dv0 = dv_count;
    send_frame(8'h96, 214, 1'b1, 8);
    idle(100);
    check("fast_sender_data", data, 8'h96);
    send_frame(8'h00, N, 1'b1, 8);
    idle(100);
    send_frame(8'h96, 224, 1'b1, 8);
    idle(100);
    check("slow_sender_data", data, 8'h96);
    check("rate_dv_count", dv_count - dv0, 3);

    idle(50);
    check("no_pending_events", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
